// File: rtl/led_alert_ctrl.sv
// LED alert controller: off / chase / bounce / alarm light patterns with an
// optional buzzer. Define LED_ALERT_BUZZER_EN to build the buzzer tone
// divider and endpoint clicks. Without it, buzzer_out is tied to 0.
module led_alert_ctrl #(
    parameter int unsigned LED_W       = 18,
    parameter int unsigned TICK_CYCLES = 5_000_000,
    parameter int unsigned BEEP_HALF   = 25_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led_out,
    output logic             buzzer_out,
    output logic             tick_out
);

    typedef enum logic [1:0] {
        ModeOff    = 2'b00,
        ModeChase  = 2'b01,
        ModeBounce = 2'b10,
        ModeAlarm  = 2'b11
    } mode_e;

    localparam int unsigned      CNT_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);
    localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);
    localparam logic [LED_W-1:0] LED_ALL = {LED_W{1'b1}};

    mode_e            mode_in;
    mode_e            mode_q;
    logic             mode_chg;
    logic             step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [LED_W-1:0] up_next, dn_next;
    logic             dir_q, dir_d;   // 1 = moving toward the MSB

    assign mode_in  = mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);
    // A due tick is dropped when the mode changes on the same edge.
    assign step     = (cnt_q == CNT_MAX) && !mode_chg;
    assign tick_out = step && (mode_q != ModeOff);
    assign up_next  = led_q << 1;
    assign dn_next  = led_q >> 1;
    assign led_out  = led_q;

    // Step-period counter, restarted by a mode change.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mode_chg || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Pattern next state: initial load on mode change, advance on a step.
    always_comb begin
        led_d = led_q;
        dir_d = dir_q;
        if (mode_chg) begin
            dir_d = 1'b1;
            unique case (mode_in)
                ModeOff:              led_d = '0;
                ModeChase, ModeBounce: led_d = LED_ONE;
                ModeAlarm:            led_d = LED_ALL;
                default:              led_d = '0;
            endcase
        end else if (step) begin
            unique case (mode_q)
                ModeOff:   led_d = '0;
                ModeChase: led_d = up_next | (led_q >> (LED_W - 1));
                ModeBounce: begin
                    if (LED_W > 1) begin
                        if (dir_q) begin
                            led_d = up_next;
                            if (up_next[LED_W-1]) dir_d = 1'b0;
                        end else begin
                            led_d = dn_next;
                            if (dn_next[0]) dir_d = 1'b1;
                        end
                    end
                end
                ModeAlarm: led_d = ~led_q;
                default:   led_d = led_q;
            endcase
        end
    end

    // Mode, counter and pattern registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= ModeOff;
            cnt_q  <= '0;
            led_q  <= '0;
            dir_q  <= 1'b1;
        end else begin
            mode_q <= mode_in;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
        end
    end

`ifdef LED_ALERT_BUZZER_EN
    localparam int unsigned       BEEP_W   = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [BEEP_W-1:0] BEEP_MAX = BEEP_W'(BEEP_HALF - 1);

    logic              click;
    logic [BEEP_W-1:0] div_q, div_d;
    logic              buz_q, buz_d;

    // Endpoint click: chase wrap, or bounce arriving at either end.
    always_comb begin
        click = 1'b0;
        if (step) begin
            if (mode_q == ModeChase) begin
                click = led_q[LED_W-1];
            end else if ((mode_q == ModeBounce) && (LED_W > 1)) begin
                click = dir_q ? up_next[LED_W-1] : dn_next[0];
            end
        end
    end

    // Tone runs only while all-ones is held; every load or step restarts it silent.
    always_comb begin
        div_d = '0;
        buz_d = 1'b0;
        if (!mode_chg) begin
            if (mode_q == ModeAlarm) begin
                if (!step && (led_q == LED_ALL)) begin
                    if (div_q == BEEP_MAX) begin
                        buz_d = ~buz_q;
                    end else begin
                        div_d = div_q + BEEP_W'(1);
                        buz_d = buz_q;
                    end
                end
            end else if ((mode_q == ModeChase) || (mode_q == ModeBounce)) begin
                buz_d = click;
            end
        end
    end

    // Buzzer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            buz_q <= 1'b0;
        end else begin
            div_q <= div_d;
            buz_q <= buz_d;
        end
    end

    assign buzzer_out = buz_q;
`else
    assign buzzer_out = 1'b0;
`endif

endmodule

// File: doc/led_alert_ctrl.md
LED_ALERT_CTRL -- requirements
Module: led_alert_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 18, the number of LED outputs (allowed range 1..32).
REQ-002 SHALL have parameter TICK_CYCLES, default 5_000_000, the pattern step period in clk cycles (100 ms at 50 MHz; minimum 2).
REQ-003 SHALL have parameter BEEP_HALF, default 25_000, the buzzer tone half-period in clk cycles (1 kHz at 50 MHz; minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: the single 50 MHz clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mode, input, 2 bits: 00 off, 01 chase, 10 bounce, 11 alarm; synchronous to clk.
REQ-007 SHALL have port led_out, output, LED_W bits: registered LED drive.
REQ-008 SHALL have port buzzer_out, output, 1 bit: registered buzzer drive.
REQ-009 SHALL have port tick_out, output, 1 bit: one-cycle pulse on every pattern step.

Function
REQ-010 SHALL register mode into mode_q every cycle; all pattern logic SHALL use mode_q.
REQ-011 SHALL detect a mode change when mode != mode_q, then in the same edge:
- clear the tick counter;
- load the mode's initial pattern (off: 0; chase: bit0 = 1; bounce: bit0 = 1 with direction up; alarm: all ones);
- clear the buzzer phase and divider.
- Result: led_out shows the new pattern exactly 1 cycle after mode changes.
REQ-012 SHALL keep a tick counter of width clog2(TICK_CYCLES):
- counts 0..TICK_CYCLES-1, then wraps to 0;
- the step occurs and tick_out = 1 for one cycle when the counter equals TICK_CYCLES-1;
- tick_out stays 0 in mode off.
REQ-013 Off: led_out = 0 and buzzer_out = 0 held; the counter SHALL still run.
REQ-014 Chase: each step rotates led_out left by 1; the MSB wraps to bit0; exactly one bit is set at all times.
REQ-015 Bounce: each step shifts the single lit bit in the current direction.
- Direction flips when the bit reaches LED_W-1 (going up) or bit0 (going down), so the endpoints are not repeated.
- For LED_W = 1, the pattern is held constant at 1.
REQ-016 Alarm: each step inverts led_out (all ones <-> all zeros).
REQ-017 Alarm buzzer: while led_out is all ones, buzzer_out SHALL toggle every BEEP_HALF cycles; while led_out is all zeros, buzzer_out = 0 and the divider is cleared.
REQ-018 Chase and bounce: buzzer_out = 1 for the single cycle coinciding with each wrap or direction flip (endpoint click); otherwise 0.
REQ-019 A mode change SHALL take priority over a tick that occurs in the same cycle; the tick is discarded.
REQ-020 Every counter SHALL saturate to no value outside its stated range; arithmetic SHALL be sized to its counter width with no implicit truncation of constants.

Reset
REQ-021 While rst = 0, asynchronously:
- led_out = 0, buzzer_out = 0, tick_out = 0;
- mode_q = 00, direction = up;
- tick counter and buzzer divider = 0.
REQ-022 After rst deasserts, a nonzero mode SHALL be treated as a mode change on the first clk edge, giving its initial pattern 1 cycle later.
REQ-023 Reset asserted mid-pattern SHALL discard all pattern state; no step completes after reset deasserts until a full TICK_CYCLES period has elapsed.

Configuration
REQ-024 Macro LED_ALERT_BUZZER_EN:
- Defined: buzzer behaviour per REQ-017/018.
- Undefined: buzzer_out is tied to constant 0, and the buzzer divider and click logic are absent from the netlist; LED and tick behaviour are unchanged.

Verification (LED_W=4, TICK_CYCLES=4, BEEP_HALF=2, macro defined)
REQ-025 Reset, then mode=01 -> led_out=0001 one cycle later; then 0010, 0100, 1000, 0001 at 4-cycle intervals; tick_out pulses each step; buzzer_out=1 on the 1000->0001 step only.
REQ-026 mode=10 -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; buzzer clicks on the steps arriving at 1000 and at 0001.
REQ-027 mode=11 -> 1111 held 4 cycles with buzzer_out 0,0,1,1 pattern (toggling every 2 cycles), then 0000 with buzzer_out=0, repeating.
REQ-028 Change mode 01 -> 11 in the same cycle a tick is due -> tick ignored, led_out=1111 next cycle, counter restarts at 0.
REQ-029 Assert rst mid-alarm -> all outputs 0 immediately (asynchronously); release with mode=11 -> 1111 after 1 cycle; first inversion 4 cycles later.
REQ-030 Rebuild without LED_ALERT_BUZZER_EN, repeat REQ-027 -> identical led_out, buzzer_out constantly 0.
